rob_multiport: RTL
==================

# rob_multiport

Parametrised reorder buffer, the successor of the single-writeback ROB. It takes in-order allocations from the decoder and accepts out-of-order results on `WB_PORTS` writeback channels. It retires one entry per cycle, in program order, to the register file (writes) or the LSB (store release, with handshake), and on a mispredicted branch it flushes and redirects the fetcher. It sits between the decoder/issue stage, RS/LSB/ALU writeback, the RegFile and IFetch.

## Interface
- `ROB_DEPTH_BIT`, 4: log2 of entry count (DEPTH = 2^ROB_DEPTH_BIT, 2..64 entries).
- `WB_PORTS`, 2: number of writeback channels (1..4).
- `clk_in`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst_in`  in  1  synchronous active-high reset.
- `rdy_in`  in  1  global stall; when low, all state frozen.
- `alloc_valid`  in  1  allocate an entry at tail this cycle.
- `alloc_ready`  out  1  (count < DEPTH) && !flush_out.
- `alloc_type`  in  2  0 NOP, 1 RD, 2 STORE, 3 BRANCH.
- `alloc_rd`  in  5  destination register; 0 = no register write.
- `alloc_done`, `alloc_value`  in  1/32  entry already complete (LUI/AUIPC/JAL link) with its value.
- `alloc_pc`  in  32  instruction address, for debug/commit trace.
- `alloc_tag`  out  ROB_DEPTH_BIT  current tail index, i.e. the tag given to this allocation.
- `wb_valid`  in  WB_PORTS  per-channel result strobe.
- `wb_id`  in  WB_PORTS*ROB_DEPTH_BIT  packed target tags.
- `wb_val`  in  WB_PORTS*32  packed results (rd value, or link value for BRANCH).
- `wb_mispred`  in  WB_PORTS  BRANCH only: prediction was wrong.
- `wb_target`  in  WB_PORTS*32  BRANCH only: correct next PC.
- `q_id`  in  2*ROB_DEPTH_BIT  two operand-query tags.
- `q_ready`, `q_val`  out  2 / 64  query result is available, and its value.
- `cm_reg_valid`, `cm_reg_rd`, `cm_reg_val`, `cm_reg_tag`  out  1/5/32/ROB_DEPTH_BIT  register commit.
- `st_release_valid`, `st_release_tag`  out  1/ROB_DEPTH_BIT  head store may write memory.
- `st_release_ready`  in  1  LSB accepts the release.
- `flush_out`, `flush_pc`  out  1/32  pipeline flush and redirect PC (registered).
- `count`  out  ROB_DEPTH_BIT+1  occupied entries.

## Operation
- Entry fields: valid, done, type, rd, value, mispred, target, pc.
- Allocate when `alloc_valid && alloc_ready && rdy_in`:
  - write the entry at tail; done = alloc_done;
  - tail wraps modulo DEPTH.
- Writeback: for each channel with `wb_valid[k]`, if the target entry is valid, set done, value, mispred and target.
  - A writeback to an invalid entry is ignored.
  - Two channels hitting the same tag is illegal; the higher index wins.
- Head retires when valid && done && rdy_in:
  - NOP: retire.
  - RD: `cm_reg_valid` asserts, with rd/val/tag, only when rd != 0. The entry still retires.
  - STORE: `st_release_valid` asserts; the entry retires only in a cycle where `st_release_ready` is 1. Otherwise head holds.
  - BRANCH: commit the link value as for RD when rd != 0. If mispred, flush.
- Flush on a mispredicted BRANCH retire edge:
  - all entries invalidate; head = tail = count = 0;
  - the same-cycle allocation is discarded;
  - `flush_out` goes to 1 for exactly one rdy_in-cycle, with `flush_pc` = target.
  - During that cycle all wb and alloc inputs are ignored.
- Query k, combinational, priority order:
  1. entry done → stored value;
  2. any wb channel hitting that tag this cycle → that wb_val (highest index first);
  3. alloc_valid && alloc_done && tag == tail → alloc_value;
  4. otherwise q_ready = 0, q_val = 0.
- count: +1 on alloc, -1 on retire, unchanged when both happen.

## Timing
- Reset values:
  - head = tail = count = 0; all entries invalid;
  - alloc_ready = 1;
  - flush_out = 0; flush_pc = 0;
  - every commit and release strobe = 0; q_ready = 0.
- Commit strobes are combinational from head state and gated by rdy_in.
- Latency:
  - An entry written back at edge N can retire at edge N+1; its commit strobe is visible during cycle N+1.
  - An allocation with alloc_done = 1 at edge N is likewise visible during cycle N+1.
- Full (count = DEPTH): alloc_ready = 0, even if head retires that cycle (no same-cycle credit).
- Empty: no strobes.
- rdy_in low: no state change; `flush_out` holds its value.
- rst_in in any cycle, including a flush cycle, overrides everything.

## Structure
- Package `rob_pkg`:
  - type encodings ROB_NOP/RD/STORE/BRANCH;
  - entry struct/field widths;
  - default ROB_DEPTH_BIT.
- Sub-module `rob_query_port`: one instance per query. It does the tag lookup, wb bypass and alloc bypass, and is parametrised by WB_PORTS.

## Test plan
- Allocate RD rd=5 at tag 0, then wb ch1 tag 0 val 0x1234 → next cycle cm_reg_valid=1, rd=5, val=0x1234, tag 0; count returns to 0.
- Fill 16 entries → alloc_ready=0, count=16. Complete head → one retire, alloc_ready=1. Tail wraps to tag 0.
- STORE at head, done, st_release_ready low for 3 cycles → st_release_valid held 3 cycles, head fixed; retires on the first ready cycle.
- BRANCH at head with wb_mispred=1, target 0x100, 4 younger entries, alloc in the same cycle → flush_out=1 for one cycle, flush_pc=0x100, count=0, the allocation is lost.
- q_id=tag 3 while ch0 writes tag 3 val 7 → q_ready=1, q_val=7 in that same cycle. q on an empty tag → q_ready=0.
- rdy_in low for 2 cycles with a done head → no strobes, state unchanged. rst_in mid-fill → all outputs at reset values.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and defaults for the multi-port reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEPTH_BIT_DEF = 4;
  localparam int unsigned WB_PORTS_DEF      = 2;
  localparam int unsigned XLEN              = 32;
  localparam int unsigned REG_W             = 5;
  localparam int unsigned QUERY_PORTS       = 2;

  typedef enum logic [1:0] {
    ROB_NOP    = 2'd0,
    ROB_RD     = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_BRANCH = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic             valid;
    logic             done;
    rob_type_e        typ;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
    logic             mispred;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_multiport_if.sv
// Decoder / writeback / commit / query bundle around the reorder buffer.
interface rob_multiport_if
  import rob_pkg::*;
#(
  parameter int unsigned ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
  parameter int unsigned WB_PORTS      = WB_PORTS_DEF
) ();

  logic                              alloc_valid;
  logic                              alloc_ready;
  logic [1:0]                        alloc_type;
  logic [REG_W-1:0]                  alloc_rd;
  logic                              alloc_done;
  logic [XLEN-1:0]                   alloc_value;
  logic [XLEN-1:0]                   alloc_pc;
  logic [ROB_DEPTH_BIT-1:0]          alloc_tag;

  logic [WB_PORTS-1:0]               wb_valid;
  logic [WB_PORTS*ROB_DEPTH_BIT-1:0] wb_id;
  logic [WB_PORTS*XLEN-1:0]          wb_val;
  logic [WB_PORTS-1:0]               wb_mispred;
  logic [WB_PORTS*XLEN-1:0]          wb_target;

  logic [QUERY_PORTS*ROB_DEPTH_BIT-1:0] q_id;
  logic [QUERY_PORTS-1:0]               q_ready;
  logic [QUERY_PORTS*XLEN-1:0]          q_val;

  logic                              cm_reg_valid;
  logic [REG_W-1:0]                  cm_reg_rd;
  logic [XLEN-1:0]                   cm_reg_val;
  logic [ROB_DEPTH_BIT-1:0]          cm_reg_tag;
  logic [XLEN-1:0]                   cm_pc;

  logic                              st_release_valid;
  logic [ROB_DEPTH_BIT-1:0]          st_release_tag;
  logic                              st_release_ready;

  logic                              flush_out;
  logic [XLEN-1:0]                   flush_pc;
  logic [ROB_DEPTH_BIT:0]            count;

  // ROB side
  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, alloc_done, alloc_value, alloc_pc,
    input  wb_valid, wb_id, wb_val, wb_mispred, wb_target,
    input  q_id, st_release_ready,
    output alloc_ready, alloc_tag, q_ready, q_val,
    output cm_reg_valid, cm_reg_rd, cm_reg_val, cm_reg_tag, cm_pc,
    output st_release_valid, st_release_tag, flush_out, flush_pc, count
  );

  // Pipeline side
  modport master (
    output alloc_valid, alloc_type, alloc_rd, alloc_done, alloc_value, alloc_pc,
    output wb_valid, wb_id, wb_val, wb_mispred, wb_target,
    output q_id, st_release_ready,
    input  alloc_ready, alloc_tag, q_ready, q_val,
    input  cm_reg_valid, cm_reg_rd, cm_reg_val, cm_reg_tag, cm_pc,
    input  st_release_valid, st_release_tag, flush_out, flush_pc, count
  );

endinterface

// File: rtl/rob_query_port.sv
// One operand query: stored value, then same-cycle writeback, then same-cycle allocation.
module rob_query_port
  import rob_pkg::*;
#(
  parameter int unsigned ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
  parameter int unsigned WB_PORTS      = WB_PORTS_DEF
) (
  input  logic [ROB_DEPTH_BIT-1:0]                  q_id,
  input  logic [(1<<ROB_DEPTH_BIT)-1:0]             ent_ready,
  input  logic [(1<<ROB_DEPTH_BIT)-1:0][XLEN-1:0]   ent_value,
  input  logic [WB_PORTS-1:0]                       wb_valid,
  input  logic [WB_PORTS*ROB_DEPTH_BIT-1:0]         wb_id,
  input  logic [WB_PORTS*XLEN-1:0]                  wb_val,
  input  logic                                      alloc_valid,
  input  logic                                      alloc_done,
  input  logic [ROB_DEPTH_BIT-1:0]                  tail,
  input  logic [XLEN-1:0]                           alloc_value,
  output logic                                      ready_c,
  output logic [XLEN-1:0]                           val_c
);

  // Lowest priority source first; later matches overwrite earlier ones.
  always_comb begin
    ready_c = 1'b0;
    val_c   = '0;
    if (alloc_valid && alloc_done && (q_id == tail)) begin
      ready_c = 1'b1;
      val_c   = alloc_value;
    end
    for (int k = 0; k < int'(WB_PORTS); k++) begin
      if (wb_valid[k] && (wb_id[k*ROB_DEPTH_BIT +: ROB_DEPTH_BIT] == q_id)) begin
        ready_c = 1'b1;
        val_c   = wb_val[k*XLEN +: XLEN];
      end
    end
    if (ent_ready[q_id]) begin
      ready_c = 1'b1;
      val_c   = ent_value[q_id];
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order alloc, multi-channel out-of-order writeback,
// single in-order retire with store handshake and mispredict flush.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int unsigned ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
  parameter int unsigned WB_PORTS      = WB_PORTS_DEF
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  rob_multiport_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ROB_DEPTH_BIT;
  localparam int unsigned CNT_W = ROB_DEPTH_BIT + 1;

  rob_entry_t                ent_q [DEPTH];
  rob_entry_t                ent_d [DEPTH];
  logic [ROB_DEPTH_BIT-1:0]  head_q, head_d;
  logic [ROB_DEPTH_BIT-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      flush_q, flush_d;
  logic [XLEN-1:0]           flush_pc_q, flush_pc_d;

  rob_entry_t                head_ent;
  logic                      head_ok_c;
  logic                      is_store_c;
  logic                      has_link_c;
  logic                      retire_c;
  logic                      flush_c;
  logic                      alloc_ready_c;
  logic                      alloc_fire_c;

  logic [DEPTH-1:0]                   ent_ready;
  logic [DEPTH-1:0][XLEN-1:0]         ent_value;
  logic [QUERY_PORTS-1:0]             q_ready_c;
  logic [QUERY_PORTS-1:0][XLEN-1:0]   q_val_c;

  // Head decode: what can leave the buffer this cycle.
  always_comb begin
    head_ent      = ent_q[head_q];
    head_ok_c     = head_ent.valid && head_ent.done && rdy_in;
    is_store_c    = (head_ent.typ == ROB_STORE);
    has_link_c    = ((head_ent.typ == ROB_RD) || (head_ent.typ == ROB_BRANCH)) &&
                    (head_ent.rd != '0);
    retire_c      = head_ok_c && (!is_store_c || bus.st_release_ready);
    flush_c       = retire_c && (head_ent.typ == ROB_BRANCH) && head_ent.mispred;
    alloc_ready_c = (count_q < CNT_W'(DEPTH)) && !flush_q;
    alloc_fire_c  = bus.alloc_valid && alloc_ready_c && rdy_in;
  end

  // Next state: writeback, allocate, retire, then flush overrides all of it.
  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy_in) begin
      flush_d = 1'b0;
      if (!flush_q) begin
        for (int k = 0; k < int'(WB_PORTS); k++) begin
          if (bus.wb_valid[k] && ent_q[bus.wb_id[k*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].valid) begin
            ent_d[bus.wb_id[k*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].done    = 1'b1;
            ent_d[bus.wb_id[k*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].value   = bus.wb_val[k*XLEN +: XLEN];
            ent_d[bus.wb_id[k*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].mispred = bus.wb_mispred[k];
            ent_d[bus.wb_id[k*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].target  = bus.wb_target[k*XLEN +: XLEN];
          end
        end
        if (alloc_fire_c) begin
          ent_d[tail_q] = '{valid:   1'b1,
                            done:    bus.alloc_done,
                            typ:     rob_type_e'(bus.alloc_type),
                            rd:      bus.alloc_rd,
                            value:   bus.alloc_value,
                            mispred: 1'b0,
                            target:  '0,
                            pc:      bus.alloc_pc};
          tail_d = tail_q + ROB_DEPTH_BIT'(1);
        end
        if (retire_c) begin
          ent_d[head_q].valid = 1'b0;
          head_d = head_q + ROB_DEPTH_BIT'(1);
        end
        case ({alloc_fire_c, retire_c})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
        if (flush_c) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            ent_d[i].valid = 1'b0;
          end
          head_d     = '0;
          tail_d     = '0;
          count_d    = '0;
          flush_d    = 1'b1;
          flush_pc_d = head_ent.target;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Flatten completed entries for the query lookups.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_ready[i] = ent_q[i].valid && ent_q[i].done;
      ent_value[i] = ent_q[i].value;
    end
  end

  for (genvar g = 0; g < int'(QUERY_PORTS); g++) begin : g_query
    rob_query_port #(
      .ROB_DEPTH_BIT (ROB_DEPTH_BIT),
      .WB_PORTS      (WB_PORTS)
    ) u_query (
      .q_id        (bus.q_id[g*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]),
      .ent_ready   (ent_ready),
      .ent_value   (ent_value),
      .wb_valid    (bus.wb_valid),
      .wb_id       (bus.wb_id),
      .wb_val      (bus.wb_val),
      .alloc_valid (bus.alloc_valid),
      .alloc_done  (bus.alloc_done),
      .tail        (tail_q),
      .alloc_value (bus.alloc_value),
      .ready_c     (q_ready_c[g]),
      .val_c       (q_val_c[g])
    );
  end

  // Output drive; commit strobes come straight from the head.
  assign bus.alloc_ready      = alloc_ready_c;
  assign bus.alloc_tag        = tail_q;
  assign bus.count            = count_q;
  assign bus.flush_out        = flush_q;
  assign bus.flush_pc         = flush_pc_q;
  assign bus.q_ready          = q_ready_c;
  assign bus.q_val            = q_val_c;
  assign bus.cm_reg_valid     = head_ok_c && has_link_c;
  assign bus.cm_reg_rd        = (head_ok_c && has_link_c) ? head_ent.rd : '0;
  assign bus.cm_reg_val       = (head_ok_c && has_link_c) ? head_ent.value : '0;
  assign bus.cm_reg_tag       = (head_ok_c && has_link_c) ? head_q : '0;
  assign bus.cm_pc            = head_ok_c ? head_ent.pc : '0;
  assign bus.st_release_valid = head_ok_c && is_store_c;
  assign bus.st_release_tag   = (head_ok_c && is_store_c) ? head_q : '0;

endmodule
